// File: rtl/sa1_mmc_regs.sv
// sa1_mmc_regs
// ------------
// SNES-side write decoder and holding register file for the SA-1 memory
// mapping controls. CPU writes to $2220-$2224 (MMC bank registers) and to
// $2230-$2231 (DMA control) land in shadow registers. The shadow is copied to
// the live outputs only at a SNES bus-cycle boundary, or after COMMIT_TIMEOUT
// idle clocks. This keeps the ROM/BW-RAM mapping from changing in the middle
// of an access.
//
// Parameters:
//   COMMIT_TIMEOUT   CLK cycles after the last captured write before a forced
//                    commit when no SNES_CYCLE_END arrives (1-255)
//
// Optional feature (macro SA1_MMC_READBACK_EN):
//   When defined, this adds mmc_rb_sel[2:0] / mmc_rb_data[7:0]. This is a
//   registered debug view of the live registers for the MCU.
//
// Ports:
//   CLK             system clock
//   RST_N           asynchronous active-low reset
//   SNES_ADDR       SNES CPU address (CLK-synchronous)
//   SNES_DATA_IN    SNES write data, valid with SNES_WR_STROBE
//   SNES_WR_STROBE  one-CLK pulse per SNES write cycle
//   SNES_CYCLE_END  one-CLK pulse at the end of each SNES bus cycle
//   mcu_cfg_req     MCU request to reload defaults (level, held until ack)
//   mcu_cfg_ack     one-CLK pulse when the defaults reload is done
//   sa1_xxb         live bank blocks {FXB,EXB,DXB,CXB}
//   sa1_xxb_en      live bank-mode enables {F,E,D,C}
//   sa1_bmaps_sbm   live BW-RAM 8K block select
//   sa1_dma_cc1_en  live character-conversion type-1 DMA enable
//   mmc_pending     an uncommitted write is held in the shadow
//   mmc_rb_sel      (readback only) debug view select
//   mmc_rb_data     (readback only) debug view data, one CLK latency

module sa1_mmc_regs #(
    parameter int COMMIT_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] SNES_ADDR,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        SNES_WR_STROBE,
    input  logic        SNES_CYCLE_END,
    input  logic        mcu_cfg_req,
    output logic        mcu_cfg_ack,
    output logic [11:0] sa1_xxb,
    output logic [3:0]  sa1_xxb_en,
    output logic [4:0]  sa1_bmaps_sbm,
    output logic        sa1_dma_cc1_en,
`ifdef SA1_MMC_READBACK_EN
    input  logic [2:0]  mmc_rb_sel,
    output logic [7:0]  mmc_rb_data,
`endif
    output logic        mmc_pending
);

    localparam logic [7:0]  TIMEOUT_LD = 8'(COMMIT_TIMEOUT);
    localparam logic [11:0] XXB_DEF    = 12'h688;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic        req_done;   // blocks re-entry into LOAD until mcu_cfg_req drops

    logic [11:0] sh_xxb;
    logic [3:0]  sh_xxb_en;
    logic [4:0]  sh_bmaps;
    logic [2:0]  sh_dcnt;    // {DMAEN, CDEN, CDSEL}
    logic [2:0]  live_dcnt;

    // Shadow contents after merging the current write (if any)
    logic        hit;
    logic [11:0] wr_xxb;
    logic [3:0]  wr_xxb_en;
    logic [4:0]  wr_bmaps;
    logic [2:0]  wr_dcnt;

    logic unused_bits;
    assign unused_bits = ^{SNES_ADDR[23], SNES_ADDR[21:16], SNES_DATA_IN[6]};

    always_comb begin
        hit       = 1'b0;
        wr_xxb    = sh_xxb;
        wr_xxb_en = sh_xxb_en;
        wr_bmaps  = sh_bmaps;
        wr_dcnt   = sh_dcnt;
        if (SNES_WR_STROBE && !SNES_ADDR[22]) begin
            case (SNES_ADDR[15:0])
                16'h2220: begin
                    hit = 1'b1;
                    wr_xxb[2:0]  = SNES_DATA_IN[2:0];
                    wr_xxb_en[0] = SNES_DATA_IN[7];
                end
                16'h2221: begin
                    hit = 1'b1;
                    wr_xxb[5:3]  = SNES_DATA_IN[2:0];
                    wr_xxb_en[1] = SNES_DATA_IN[7];
                end
                16'h2222: begin
                    hit = 1'b1;
                    wr_xxb[8:6]  = SNES_DATA_IN[2:0];
                    wr_xxb_en[2] = SNES_DATA_IN[7];
                end
                16'h2223: begin
                    hit = 1'b1;
                    wr_xxb[11:9] = SNES_DATA_IN[2:0];
                    wr_xxb_en[3] = SNES_DATA_IN[7];
                end
                16'h2224: begin
                    hit = 1'b1;
                    wr_bmaps = SNES_DATA_IN[4:0];
                end
                16'h2230: begin
                    hit = 1'b1;
                    wr_dcnt = {SNES_DATA_IN[7], SNES_DATA_IN[5], SNES_DATA_IN[4]};
                end
                16'h2231: begin
                    // CDMA: only the "end of conversion" bit matters here; it stops DMA
                    hit = 1'b1;
                    if (SNES_DATA_IN[7]) wr_dcnt[2] = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            req_done       <= 1'b0;
            mcu_cfg_ack    <= 1'b0;
            mmc_pending    <= 1'b0;
            sh_xxb         <= XXB_DEF;
            sh_xxb_en      <= 4'd0;
            sh_bmaps       <= 5'd0;
            sh_dcnt        <= 3'd0;
            sa1_xxb        <= XXB_DEF;
            sa1_xxb_en     <= 4'd0;
            sa1_bmaps_sbm  <= 5'd0;
            live_dcnt      <= 3'd0;
            sa1_dma_cc1_en <= 1'b0;
        end else begin
            mcu_cfg_ack <= 1'b0;
            if (!mcu_cfg_req) req_done <= 1'b0;

            if (mcu_cfg_req && !mcu_cfg_ack && !req_done) begin
                // Defaults reload wins over everything. Any pending or
                // coincident SNES write is discarded.
                state          <= LOAD;
                req_done       <= 1'b1;
                cnt            <= 8'd0;
                mmc_pending    <= 1'b0;
                sh_xxb         <= XXB_DEF;
                sh_xxb_en      <= 4'd0;
                sh_bmaps       <= 5'd0;
                sh_dcnt        <= 3'd0;
                sa1_xxb        <= XXB_DEF;
                sa1_xxb_en     <= 4'd0;
                sa1_bmaps_sbm  <= 5'd0;
                live_dcnt      <= 3'd0;
                sa1_dma_cc1_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hit) begin
                            sh_xxb      <= wr_xxb;
                            sh_xxb_en   <= wr_xxb_en;
                            sh_bmaps    <= wr_bmaps;
                            sh_dcnt     <= wr_dcnt;
                            cnt         <= TIMEOUT_LD;
                            state       <= PEND;
                            mmc_pending <= 1'b1;
                        end
                    end
                    PEND: begin
                        // On a commit, live takes the shadow as it was before
                        // any coincident write. That write then stays pending.
                        if (SNES_CYCLE_END || cnt == 8'd0) begin
                            sa1_xxb        <= sh_xxb;
                            sa1_xxb_en     <= sh_xxb_en;
                            sa1_bmaps_sbm  <= sh_bmaps;
                            live_dcnt      <= sh_dcnt;
                            sa1_dma_cc1_en <= &sh_dcnt;
                            if (!hit) begin
                                state       <= IDLE;
                                mmc_pending <= 1'b0;
                            end
                        end
                        if (hit) begin
                            sh_xxb    <= wr_xxb;
                            sh_xxb_en <= wr_xxb_en;
                            sh_bmaps  <= wr_bmaps;
                            sh_dcnt   <= wr_dcnt;
                            cnt       <= TIMEOUT_LD;
                        end else if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    LOAD: begin
                        // SNES hits are dropped here
                        mcu_cfg_ack <= 1'b1;
                        state       <= IDLE;
                    end
                    default: begin
                        state       <= IDLE;
                        mmc_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef SA1_MMC_READBACK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mmc_rb_data <= 8'h00;
        end else begin
            case (mmc_rb_sel)
                3'd0:    mmc_rb_data <= {sa1_xxb_en[0], 4'b0, sa1_xxb[2:0]};
                3'd1:    mmc_rb_data <= {sa1_xxb_en[1], 4'b0, sa1_xxb[5:3]};
                3'd2:    mmc_rb_data <= {sa1_xxb_en[2], 4'b0, sa1_xxb[8:6]};
                3'd3:    mmc_rb_data <= {sa1_xxb_en[3], 4'b0, sa1_xxb[11:9]};
                3'd4:    mmc_rb_data <= {3'b0, sa1_bmaps_sbm};
                3'd5:    mmc_rb_data <= {live_dcnt[2], 1'b0, live_dcnt[1:0], 4'b0};
                3'd6:    mmc_rb_data <= {7'b0, mmc_pending};
                default: mmc_rb_data <= 8'h00;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_sa1_mmc_regs.sv
// Directed testbench for sa1_mmc_regs.
module tb_sa1_mmc_regs;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [23:0] SNES_ADDR = 24'd0;
    logic [7:0]  SNES_DATA_IN = 8'd0;
    logic        SNES_WR_STROBE = 1'b0;
    logic        SNES_CYCLE_END = 1'b0;
    logic        mcu_cfg_req = 1'b0;
    logic        mcu_cfg_ack;
    logic [11:0] sa1_xxb;
    logic [3:0]  sa1_xxb_en;
    logic [4:0]  sa1_bmaps_sbm;
    logic        sa1_dma_cc1_en;
    logic        mmc_pending;
`ifdef SA1_MMC_READBACK_EN
    logic [2:0]  mmc_rb_sel = 3'd0;
    logic [7:0]  mmc_rb_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    sa1_mmc_regs #(.COMMIT_TIMEOUT(TO)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .SNES_ADDR      (SNES_ADDR),
        .SNES_DATA_IN   (SNES_DATA_IN),
        .SNES_WR_STROBE (SNES_WR_STROBE),
        .SNES_CYCLE_END (SNES_CYCLE_END),
        .mcu_cfg_req    (mcu_cfg_req),
        .mcu_cfg_ack    (mcu_cfg_ack),
        .sa1_xxb        (sa1_xxb),
        .sa1_xxb_en     (sa1_xxb_en),
        .sa1_bmaps_sbm  (sa1_bmaps_sbm),
        .sa1_dma_cc1_en (sa1_dma_cc1_en),
`ifdef SA1_MMC_READBACK_EN
        .mmc_rb_sel     (mmc_rb_sel),
        .mmc_rb_data    (mmc_rb_data),
`endif
        .mmc_pending    (mmc_pending)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic snes_write(input logic [23:0] addr, input logic [7:0] data, input logic end_too);
        SNES_ADDR      = addr;
        SNES_DATA_IN   = data;
        SNES_WR_STROBE = 1'b1;
        SNES_CYCLE_END = end_too;
        tick();
        SNES_WR_STROBE = 1'b0;
        SNES_CYCLE_END = 1'b0;
    endtask

    task automatic cycle_end();
        SNES_CYCLE_END = 1'b1;
        tick();
        SNES_CYCLE_END = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();
        tests_run++;
        if (sa1_xxb !== 12'h688) begin tests_failed++; $display("FAIL reset_xxb: got %h expected 688", sa1_xxb); end
        tests_run++;
        if (sa1_xxb_en !== 4'h0) begin tests_failed++; $display("FAIL reset_xxb_en: got %h expected 0", sa1_xxb_en); end
        tests_run++;
        if (sa1_bmaps_sbm !== 5'h00) begin tests_failed++; $display("FAIL reset_bmaps: got %h expected 00", sa1_bmaps_sbm); end
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b0) begin tests_failed++; $display("FAIL reset_cc1: got %b expected 0", sa1_dma_cc1_en); end
        tests_run++;
        if (mmc_pending !== 1'b0 || mcu_cfg_ack !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ctrl: got pending=%b ack=%b expected 0/0", mmc_pending, mcu_cfg_ack);
        end
    endtask

    task automatic test_bank_write();
        snes_write(24'h002221, 8'h85, 1'b0);
        tests_run++;
        if (mmc_pending !== 1'b1 || sa1_xxb !== 12'h688) begin
            tests_failed++; $display("FAIL bank_pend: got pending=%b xxb=%h expected 1/688", mmc_pending, sa1_xxb);
        end
        tick();
        tick();
        tests_run++;
        if (mmc_pending !== 1'b1 || sa1_xxb_en !== 4'h0) begin
            tests_failed++; $display("FAIL bank_hold: got pending=%b en=%h expected 1/0", mmc_pending, sa1_xxb_en);
        end
        cycle_end();
        tests_run++;
        if (sa1_xxb !== 12'h6A8) begin tests_failed++; $display("FAIL bank_xxb: got %h expected 6a8", sa1_xxb); end
        tests_run++;
        if (sa1_xxb_en !== 4'b0010) begin tests_failed++; $display("FAIL bank_en: got %b expected 0010", sa1_xxb_en); end
        tests_run++;
        if (mmc_pending !== 1'b0 || sa1_bmaps_sbm !== 5'h00 || sa1_dma_cc1_en !== 1'b0) begin
            tests_failed++; $display("FAIL bank_others: got pending=%b bmaps=%h cc1=%b expected 0/00/0",
                                     mmc_pending, sa1_bmaps_sbm, sa1_dma_cc1_en);
        end
    endtask

    task automatic test_timeout();
        snes_write(24'h002224, 8'h1F, 1'b0);
        repeat (TO) tick();
        tests_run++;
        if (sa1_bmaps_sbm !== 5'h00 || mmc_pending !== 1'b1) begin
            tests_failed++; $display("FAIL timeout_early: got bmaps=%h pending=%b expected 00/1", sa1_bmaps_sbm, mmc_pending);
        end
        tick();
        tests_run++;
        if (sa1_bmaps_sbm !== 5'h1F || mmc_pending !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_commit: got bmaps=%h pending=%b expected 1f/0", sa1_bmaps_sbm, mmc_pending);
        end
        // Bank bit 22 set, and an unmapped offset: both must be ignored
        snes_write(24'h402224, 8'h03, 1'b0);
        snes_write(24'h002225, 8'h05, 1'b0);
        tests_run++;
        if (mmc_pending !== 1'b0) begin tests_failed++; $display("FAIL ignored_pend: got %b expected 0", mmc_pending); end
        repeat (TO + 3) tick();
        cycle_end();
        tests_run++;
        if (sa1_bmaps_sbm !== 5'h1F || sa1_xxb !== 12'h6A8) begin
            tests_failed++; $display("FAIL ignored_live: got bmaps=%h xxb=%h expected 1f/6a8", sa1_bmaps_sbm, sa1_xxb);
        end
    endtask

    task automatic test_dma();
        snes_write(24'h002230, 8'hB0, 1'b0);
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b0) begin tests_failed++; $display("FAIL dma_precommit: got %b expected 0", sa1_dma_cc1_en); end
        cycle_end();
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b1) begin tests_failed++; $display("FAIL dma_on: got %b expected 1", sa1_dma_cc1_en); end
        snes_write(24'h002231, 8'h7F, 1'b0);
        cycle_end();
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b1) begin tests_failed++; $display("FAIL dma_cdma_noclr: got %b expected 1", sa1_dma_cc1_en); end
        snes_write(24'h002231, 8'h80, 1'b0);
        cycle_end();
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b0) begin tests_failed++; $display("FAIL dma_off: got %b expected 0", sa1_dma_cc1_en); end
        snes_write(24'h002230, 8'h90, 1'b0);
        cycle_end();
        tests_run++;
        if (sa1_dma_cc1_en !== 1'b0) begin tests_failed++; $display("FAIL dma_partial: got %b expected 0", sa1_dma_cc1_en); end
    endtask

    task automatic test_back_to_back();
        snes_write(24'h002220, 8'h02, 1'b0);
        snes_write(24'h002222, 8'h07, 1'b1);
        tests_run++;
        if (sa1_xxb !== 12'h6AA) begin tests_failed++; $display("FAIL b2b_first: got %h expected 6aa", sa1_xxb); end
        tests_run++;
        if (mmc_pending !== 1'b1) begin tests_failed++; $display("FAIL b2b_pend: got %b expected 1", mmc_pending); end
        cycle_end();
        tests_run++;
        if (sa1_xxb !== 12'h7EA || sa1_xxb_en !== 4'b0010 || mmc_pending !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_second: got xxb=%h en=%b pending=%b expected 7ea/0010/0",
                                     sa1_xxb, sa1_xxb_en, mmc_pending);
        end
    endtask

    task automatic test_cfg_reload();
        int acks;
        snes_write(24'h002223, 8'h81, 1'b0);
        mcu_cfg_req = 1'b1;
        tick();
        tests_run++;
        if (sa1_xxb !== 12'h688 || sa1_xxb_en !== 4'h0 || sa1_bmaps_sbm !== 5'h00) begin
            tests_failed++; $display("FAIL cfg_defaults: got xxb=%h en=%h bmaps=%h expected 688/0/00",
                                     sa1_xxb, sa1_xxb_en, sa1_bmaps_sbm);
        end
        tests_run++;
        if (mmc_pending !== 1'b0 || mcu_cfg_ack !== 1'b0) begin
            tests_failed++; $display("FAIL cfg_ctrl: got pending=%b ack=%b expected 0/0", mmc_pending, mcu_cfg_ack);
        end
        // Write during LOAD is dropped
        SNES_ADDR = 24'h002224; SNES_DATA_IN = 8'h0A; SNES_WR_STROBE = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            SNES_WR_STROBE = 1'b0;
            if (mcu_cfg_ack === 1'b1) acks++;
        end
        tests_run++;
        if (acks != 1) begin tests_failed++; $display("FAIL cfg_ack_count: got %0d expected 1", acks); end
        mcu_cfg_req = 1'b0;
        tick();
        cycle_end();
        tests_run++;
        if (sa1_xxb !== 12'h688 || sa1_bmaps_sbm !== 5'h00 || mmc_pending !== 1'b0) begin
            tests_failed++; $display("FAIL cfg_discard: got xxb=%h bmaps=%h pending=%b expected 688/00/0",
                                     sa1_xxb, sa1_bmaps_sbm, mmc_pending);
        end
    endtask

    task automatic test_reset_mid_pend();
        snes_write(24'h002220, 8'h85, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        tests_run++;
        if (mmc_pending !== 1'b0 || sa1_xxb !== 12'h688) begin
            tests_failed++; $display("FAIL async_reset: got pending=%b xxb=%h expected 0/688", mmc_pending, sa1_xxb);
        end
        tick();
        RST_N = 1'b1;
        tick();
        cycle_end();
        tests_run++;
        if (sa1_xxb !== 12'h688 || sa1_xxb_en !== 4'h0) begin
            tests_failed++; $display("FAIL reset_lost_shadow: got xxb=%h en=%h expected 688/0", sa1_xxb, sa1_xxb_en);
        end
    endtask

    initial begin
        test_reset();
        test_bank_write();
        test_timeout();
        test_dma();
        test_back_to_back();
        test_cfg_reload();
        test_reset_mid_pend();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sa1_mmc_regs.md
Name: sa1_mmc_regs

Overview:
- SNES-side write decoder and holding register file for the SA-1 memory-mapping controls.
- Captures CPU writes to the MMC bank registers ($2220-$2224) and the DMA control registers ($2230-$2231).
- Drives the live sa1_xxb, sa1_xxb_en, sa1_bmaps_sbm and sa1_dma_cc1_en signals consumed by the address decoder.
- Writes land in shadow registers and are committed to the live outputs only at a SNES bus-cycle boundary, so the ROM/BW-RAM mapping never changes mid-access.

Parameters:
COMMIT_TIMEOUT, 15, CLK cycles after the last captured write before a forced commit if no SNES_CYCLE_END arrives (range 1-255).

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; asynchronous assert, active-low
SNES_ADDR  in  24  SNES CPU address, CLK-synchronous
SNES_DATA_IN  in  8  SNES write data, valid when SNES_WR_STROBE=1
SNES_WR_STROBE  in  1  one-CLK pulse per SNES write cycle
SNES_CYCLE_END  in  1  one-CLK pulse at the end of each SNES bus cycle
mcu_cfg_req  in  1  MCU request to reload defaults (level, held until ack)
mcu_cfg_ack  out  1  one-CLK pulse, defaults reload done
sa1_xxb  out  12  live bank blocks {FXB,EXB,DXB,CXB}, 3 bits each
sa1_xxb_en  out  4  live bank-mode enables {F,E,D,C}
sa1_bmaps_sbm  out  5  live BW-RAM 8K block select for 00-3F/80-BF:6000-7FFF
sa1_dma_cc1_en  out  1  live character-conversion type-1 DMA enable
mmc_pending  out  1  shadow differs from live (uncommitted write present)

Behaviour:
- Register hit: SNES_WR_STROBE & ~SNES_ADDR[22] & SNES_ADDR[15:0] in the set below. Writes to any other address are ignored.
  - $2220/$2221/$2222/$2223 → shadow xxb[i] = data[2:0] and shadow xxb_en[i] = data[7], i = 0..3 (C, D, E, F).
  - $2224 → shadow bmaps = data[4:0].
  - $2230 (DCNT) → shadow dcnt = {data[7], data[5], data[4]}.
  - $2231 (CDMA) → if data[7]=1, clear shadow dcnt[2] (DMAEN). Other bits are ignored.
- sa1_dma_cc1_en = live dcnt[2] & dcnt[1] & dcnt[0] (DMAEN & CDEN & CDSEL). This output is registered.
- Reset, and defaults reload, set shadow and live to:
  - xxb = 12'h688 (CXB=0, DXB=1, EXB=2, FXB=3)
  - xxb_en = 0, bmaps = 0, dcnt = 0
  - mmc_pending = 0, mcu_cfg_ack = 0, timeout counter = 0
- FSM states: IDLE, PEND, LOAD.
  - IDLE: a register hit writes the shadow → PEND. The counter loads COMMIT_TIMEOUT.
  - PEND: a further hit merges into the shadow and reloads the counter. The counter decrements by 1 per CLK, saturating at 0.
  - PEND commit: SNES_CYCLE_END, or counter = 0, copies shadow to live in the next edge → IDLE.
  - PEND, commit coincident with a new hit: live takes the pre-write shadow, the new write lands in the shadow, and the state stays PEND with the counter reloaded. No write is ever lost.
  - LOAD: entered from any state when mcu_cfg_req=1 and mcu_cfg_ack=0. Defaults go into shadow and live in one cycle, any pending write is discarded, and mcu_cfg_ack pulses the following cycle → IDLE.
  - LOAD: SNES hits arriving during LOAD are dropped. The req must drop before it can be re-armed.
- mmc_pending = (state == PEND), registered.
- Live outputs change only on a commit or a LOAD. Latency is 1 CLK from SNES_CYCLE_END to live outputs updated.
- Reset asserted mid-PEND: everything returns to defaults asynchronously and the shadow contents are lost.

Optional Feature:
- Macro SA1_MMC_READBACK_EN.
  - Defined: adds input mmc_rb_sel[2:0] and output mmc_rb_data[7:0], a registered one-CLK-latency MCU debug view of the live registers:
    - sel 0-3: {xxb_en[i], 4'b0, xxb[i]}
    - sel 4: {3'b0, bmaps}
    - sel 5: {dcnt[2], 1'b0, dcnt[1:0], 4'b0}
    - sel 6: {7'b0, mmc_pending}
    - sel 7: 8'h00
    - Reset value is 8'h00.
  - Undefined: these ports do not exist and there is no added logic.

Test Plan:
- Reset release → sa1_xxb=12'h688, sa1_xxb_en=0, sa1_bmaps_sbm=0, sa1_dma_cc1_en=0, mmc_pending=0.
- Write $002221=8'h85, then SNES_CYCLE_END 3 CLK later → mmc_pending=1 until the end pulse; next CLK sa1_xxb[5:3]=5 and sa1_xxb_en[1]=1. Other fields are unchanged.
- Write $002224=8'h1F with no SNES_CYCLE_END → sa1_bmaps_sbm=5'h1F exactly COMMIT_TIMEOUT+1 CLK after the strobe. Write $402224 → ignored.
- Write $2230=8'hB0, commit → sa1_dma_cc1_en=1. Write $2231=8'h80, commit → sa1_dma_cc1_en=0.
- Write $2222=8'h07 on the same CLK as SNES_CYCLE_END while PEND holds $2220=8'h02 → live CXB=2 and EXB unchanged, mmc_pending stays 1. The next end pulse commits EXB=7.
- Pending write, then mcu_cfg_req=1 → live and shadow equal defaults, mcu_cfg_ack pulses once, the pending write never appears.
